tpu_cfg_bridge: RTL and testbench
=================================

Name: tpu_cfg_bridge

Overview:
- Parametrised successor bridge between the UART controller and the MLP top.
- Forwards weight-FIFO and activation traffic. Replaces the hard-wired activation-pipeline constants with a host-writable, double-buffered config register set that commits only while the MLP is idle.
- Captures accumulator results into a FIFO, read by the controller over a valid/ready handshake.

Parameters:
- NUM_COLS, 2, systolic columns / accumulator channels.
- ACC_W, 32, accumulator width per channel.
- FIFO_DEPTH, 4, result FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- ctrl_wf_push  in  NUM_COLS  per-column weight push; forwarded combinationally to mlp_wf_push.
- ctrl_wf_data_in / ctrl_wf_reset / ctrl_init_act_valid / ctrl_init_act_data / ctrl_weights_ready  in  8/1/1/16/1  forwarded combinationally to the mlp_* outputs of the same name.
- ctrl_start_mlp  in  1  start request (1-cycle pulse).
- cfg_we  in  1  shadow register write strobe.
- cfg_addr  in  3  0 gain, 1 bias, 2 shift, 3 inv_scale, 4 zero_point, 7 clear overflow.
- cfg_wdata  in  32  write data, LSB-aligned and truncated to the field width.
- cfg_commit  in  1  request shadow→active copy.
- res_ready  in  1  controller accepts the FIFO head.
- mlp_state_in / mlp_cycle_cnt_in / mlp_current_layer_in / mlp_layer_complete_in  in  4/5/3/1  MLP status.
- mlp_acc_in  in  NUM_COLS*ACC_W  accumulators, column 0 in the LSBs.
- mlp_acc_valid_in  in  1  accumulator vector valid.
- mlp_wf_push / mlp_wf_data_in / mlp_wf_reset / mlp_init_act_valid / mlp_init_act_data / mlp_weights_ready  out  as inputs  forwarded signals.
- mlp_start_mlp  out  1  gated/deferred start.
- mlp_norm_gain / mlp_norm_bias / mlp_norm_shift / mlp_q_inv_scale / mlp_q_zero_point  out  16s/32s/5/16s/8s  active config.
- mlp_state / mlp_cycle_cnt / mlp_current_layer / mlp_layer_complete  out  4/5/3/1  status passed combinationally to the controller.
- res_valid  out  1  FIFO not empty.
- res_data  out  NUM_COLS*ACC_W  FIFO head accumulators.
- res_layer  out  3  layer tag of the FIFO head.
- res_overflow  out  1  sticky; a push was dropped.
- cfg_pending  out  1  commit outstanding.

Behaviour:
- Reset values:
  - Active and shadow registers: gain 256, bias 0, shift 8, inv_scale 256, zp 0.
  - FIFO empty, res_valid 0, res_data 0, res_layer 0, res_overflow 0.
  - cfg_pending 0, mlp_start_mlp 0, FSM in CFG_IDLE.
  - Reset mid-operation discards FIFO contents and any pending commit/start.
- Shadow writes: cfg_we writes the shadow register at cfg_addr on the next edge. Addresses 5–6 are ignored. Address 7 clears res_overflow.
- Config FSM:
  - CFG_IDLE: cfg_commit → CFG_PENDING.
  - CFG_PENDING: when mlp_state_in==0 (IDLE), copy shadow→active on that edge. Next state is CFG_START if a start is latched, else CFG_IDLE.
  - CFG_START: mlp_start_mlp=1 for exactly one cycle, then CFG_IDLE.
- cfg_pending = (state != CFG_IDLE).
- Start gating:
  - In CFG_IDLE, mlp_start_mlp = ctrl_start_mlp (combinational).
  - Otherwise ctrl_start_mlp is latched into a start flag and never reaches the MLP until the commit is done. Multiple latched starts collapse to one.
- Commit and write on the same edge: the write lands in shadow first, so the new value is included in the copy.
- Commit while already pending: no effect.
- Result FIFO:
  - mlp_acc_valid_in pushes {mlp_current_layer_in, mlp_acc_in}.
  - Pop on res_valid && res_ready.
  - res_* driven from registered head storage; push at edge N gives res_valid=1 after edge N when previously empty.
  - Full and push without pop: data dropped, res_overflow set.
  - Full with push and pop on the same edge: both happen, count unchanged, no overflow.
  - Empty with push: no pop is possible since res_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. Count is log2(FIFO_DEPTH)+1 bits.
- Forwarded and status paths have zero latency.

Optional Feature:
- Macro: TPU_CFG_READBACK_EN.
- Defined: adds input cfg_re and outputs cfg_rdata[31:0] and cfg_rvalid.
  - cfg_re samples cfg_addr. One cycle later cfg_rvalid=1 and cfg_rdata holds the sign-extended active value (shadow value when addr bit… n/a; active only). Address 7 returns {31'b0, res_overflow}; other addresses return 0.
- Undefined: these ports do not exist and no readback logic is built.

Decomposition:
- Package tpu_bridge_pkg:
  - cfg address localparams (CFG_GAIN..CFG_CLR_OVF).
  - Reset-default constants.
  - typedef act_cfg_t packed struct {gain, bias, shift, inv_scale, zero_point}.
  - enum cfg_state_e {CFG_IDLE, CFG_PENDING, CFG_START}.
  - MLP_IDLE = 4'd0.
- Sub-module bridge_result_fifo (parametrised width/depth, flags full/empty, synchronous push/pop), instantiated once.

Test Plan:
- Reset release → gain 256, bias 0, shift 8, inv_scale 256, zp 0; res_valid 0; cfg_pending 0.
- Write gain=512, commit while mlp_state_in=3 → outputs remain 256 and cfg_pending=1. Drop state to 0 → gain=512 after that edge and cfg_pending=0.
- Commit pending, pulse ctrl_start_mlp with state busy → mlp_start_mlp stays 0. When state goes 0: one-cycle mlp_start_mlp pulse on the cycle after the copy.
- Push 4 vectors (acc0=1..4, layer 2) with res_ready=0 → res_valid=1, head acc0=1. Fifth push → res_overflow=1 and data dropped. Drain → 1,2,3,4 in order. Write addr 7 → overflow=0.
- Full FIFO with simultaneous push(acc0=9) and pop → no overflow. After draining, the last entry is 9.
- Assert reset mid-drain with pending commit → FIFO empty, defaults restored, no spurious mlp_start_mlp.

Source files
------------

// File: rtl/tpu_cfg_bridge_pkg.sv
// Shared types, config address map and reset defaults for the TPU config bridge.
package tpu_bridge_pkg;

    localparam logic [2:0] CFG_GAIN       = 3'd0;
    localparam logic [2:0] CFG_BIAS       = 3'd1;
    localparam logic [2:0] CFG_SHIFT      = 3'd2;
    localparam logic [2:0] CFG_INV_SCALE  = 3'd3;
    localparam logic [2:0] CFG_ZERO_POINT = 3'd4;
    localparam logic [2:0] CFG_CLR_OVF    = 3'd7;

    localparam logic signed [15:0] DEF_GAIN       = 16'sd256;
    localparam logic signed [31:0] DEF_BIAS       = 32'sd0;
    localparam logic        [4:0]  DEF_SHIFT      = 5'd8;
    localparam logic signed [15:0] DEF_INV_SCALE  = 16'sd256;
    localparam logic signed [7:0]  DEF_ZERO_POINT = 8'sd0;

    localparam logic [3:0] MLP_IDLE = 4'd0;

    typedef struct packed {
        logic signed [15:0] gain;
        logic signed [31:0] bias;
        logic        [4:0]  shift;
        logic signed [15:0] inv_scale;
        logic signed [7:0]  zero_point;
    } act_cfg_t;

    localparam act_cfg_t CFG_DEFAULT = '{
        gain:       DEF_GAIN,
        bias:       DEF_BIAS,
        shift:      DEF_SHIFT,
        inv_scale:  DEF_INV_SCALE,
        zero_point: DEF_ZERO_POINT
    };

    typedef enum logic [1:0] {
        CFG_IDLE,
        CFG_PENDING,
        CFG_START
    } cfg_state_e;

    // Writes are LSB-aligned and truncated to the field width.
    function automatic act_cfg_t cfg_write(input act_cfg_t cur, input logic [2:0] addr,
                                           input logic [31:0] data);
        act_cfg_t r;
        r = cur;
        case (addr)
            CFG_GAIN:       r.gain       = data[15:0];
            CFG_BIAS:       r.bias       = data;
            CFG_SHIFT:      r.shift      = data[4:0];
            CFG_INV_SCALE:  r.inv_scale  = data[15:0];
            CFG_ZERO_POINT: r.zero_point = data[7:0];
            default:        r            = cur;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] cfg_read(input act_cfg_t c, input logic [2:0] addr,
                                             input logic ovf);
        logic [31:0] r;
        case (addr)
            CFG_GAIN:       r = {{16{c.gain[15]}}, c.gain};
            CFG_BIAS:       r = c.bias;
            CFG_SHIFT:      r = {27'd0, c.shift};
            CFG_INV_SCALE:  r = {{16{c.inv_scale[15]}}, c.inv_scale};
            CFG_ZERO_POINT: r = {{24{c.zero_point[7]}}, c.zero_point};
            CFG_CLR_OVF:    r = {31'd0, ovf};
            default:        r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tpu_cfg_bridge_result_fifo.sv
// Result FIFO: register-array storage, head read straight from storage, wrapping pointers.
module bridge_result_fifo #(
    parameter int unsigned WIDTH = 67,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tpu_cfg_bridge.sv
// UART-controller to MLP bridge with double-buffered activation config and a result FIFO.
// Optional config readback port is built when TPU_CFG_READBACK_EN is defined.
module tpu_cfg_bridge
    import tpu_bridge_pkg::*;
#(
    parameter int unsigned NUM_COLS   = 2,
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_COLS-1:0]       ctrl_wf_push,
    input  logic [7:0]                ctrl_wf_data_in,
    input  logic                      ctrl_wf_reset,
    input  logic                      ctrl_init_act_valid,
    input  logic [15:0]               ctrl_init_act_data,
    input  logic                      ctrl_weights_ready,
    input  logic                      ctrl_start_mlp,
    input  logic                      cfg_we,
    input  logic [2:0]                cfg_addr,
    input  logic [31:0]               cfg_wdata,
    input  logic                      cfg_commit,
`ifdef TPU_CFG_READBACK_EN
    input  logic                      cfg_re,
    output logic [31:0]               cfg_rdata,
    output logic                      cfg_rvalid,
`endif
    input  logic                      res_ready,
    input  logic [3:0]                mlp_state_in,
    input  logic [4:0]                mlp_cycle_cnt_in,
    input  logic [2:0]                mlp_current_layer_in,
    input  logic                      mlp_layer_complete_in,
    input  logic [NUM_COLS*ACC_W-1:0] mlp_acc_in,
    input  logic                      mlp_acc_valid_in,
    output logic [NUM_COLS-1:0]       mlp_wf_push,
    output logic [7:0]                mlp_wf_data_in,
    output logic                      mlp_wf_reset,
    output logic                      mlp_init_act_valid,
    output logic [15:0]               mlp_init_act_data,
    output logic                      mlp_weights_ready,
    output logic                      mlp_start_mlp,
    output logic signed [15:0]        mlp_norm_gain,
    output logic signed [31:0]        mlp_norm_bias,
    output logic [4:0]                mlp_norm_shift,
    output logic signed [15:0]        mlp_q_inv_scale,
    output logic signed [7:0]         mlp_q_zero_point,
    output logic [3:0]                mlp_state,
    output logic [4:0]                mlp_cycle_cnt,
    output logic [2:0]                mlp_current_layer,
    output logic                      mlp_layer_complete,
    output logic                      res_valid,
    output logic [NUM_COLS*ACC_W-1:0] res_data,
    output logic [2:0]                res_layer,
    output logic                      res_overflow,
    output logic                      cfg_pending
);
    localparam int unsigned ENTRY_W = NUM_COLS * ACC_W + 3;

    cfg_state_e       state;
    cfg_state_e       state_next;
    act_cfg_t         shadow;
    act_cfg_t         shadow_next;
    act_cfg_t         active;
    logic             start_flag;
    logic             commit_now;
    logic             fifo_full;
    logic             fifo_empty;
    logic             res_pop;
    logic [ENTRY_W-1:0] fifo_head;

    assign mlp_wf_push        = ctrl_wf_push;
    assign mlp_wf_data_in     = ctrl_wf_data_in;
    assign mlp_wf_reset       = ctrl_wf_reset;
    assign mlp_init_act_valid = ctrl_init_act_valid;
    assign mlp_init_act_data  = ctrl_init_act_data;
    assign mlp_weights_ready  = ctrl_weights_ready;
    assign mlp_state          = mlp_state_in;
    assign mlp_cycle_cnt      = mlp_cycle_cnt_in;
    assign mlp_current_layer  = mlp_current_layer_in;
    assign mlp_layer_complete = mlp_layer_complete_in;

    assign mlp_norm_gain    = active.gain;
    assign mlp_norm_bias    = active.bias;
    assign mlp_norm_shift   = active.shift;
    assign mlp_q_inv_scale  = active.inv_scale;
    assign mlp_q_zero_point = active.zero_point;

    assign cfg_pending = (state != CFG_IDLE);

    // The copy uses shadow_next so a write on the commit edge is included.
    assign shadow_next = cfg_we ? cfg_write(shadow, cfg_addr, cfg_wdata) : shadow;
    assign commit_now  = (state == CFG_PENDING) && (mlp_state_in == MLP_IDLE);

    always_comb begin
        state_next    = state;
        mlp_start_mlp = 1'b0;
        case (state)
            CFG_IDLE: begin
                mlp_start_mlp = ctrl_start_mlp;
                if (cfg_commit) state_next = CFG_PENDING;
            end
            CFG_PENDING: begin
                if (commit_now)
                    state_next = (start_flag || ctrl_start_mlp) ? CFG_START : CFG_IDLE;
            end
            CFG_START: begin
                mlp_start_mlp = 1'b1;
                state_next    = CFG_IDLE;
            end
            default: state_next = CFG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= CFG_IDLE;
            start_flag <= 1'b0;
            shadow     <= CFG_DEFAULT;
            active     <= CFG_DEFAULT;
        end else begin
            state  <= state_next;
            shadow <= shadow_next;
            if (commit_now) active <= shadow_next;
            if (state == CFG_START)
                start_flag <= 1'b0;
            else if (state != CFG_IDLE && ctrl_start_mlp)
                start_flag <= 1'b1;
        end
    end

    assign res_pop   = res_valid && res_ready;
    assign res_valid = !fifo_empty;
    assign {res_layer, res_data} = fifo_head;

    bridge_result_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (mlp_acc_valid_in),
        .pop   (res_pop),
        .wdata ({mlp_current_layer_in, mlp_acc_in}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            res_overflow <= 1'b0;
        else if (mlp_acc_valid_in && fifo_full && !res_pop)
            res_overflow <= 1'b1;
        else if (cfg_we && cfg_addr == CFG_CLR_OVF)
            res_overflow <= 1'b0;
    end

`ifdef TPU_CFG_READBACK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_rvalid <= 1'b0;
            cfg_rdata  <= '0;
        end else begin
            cfg_rvalid <= cfg_re;
            if (cfg_re) cfg_rdata <= cfg_read(active, cfg_addr, res_overflow);
        end
    end
`endif

endmodule

// File: tb/tb_tpu_cfg_bridge.sv
// Directed bench for tpu_cfg_bridge: table-driven forwarding vectors plus config/FIFO sequences.
module tb_tpu_cfg_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ctrl_wf_push;
    logic [7:0]  ctrl_wf_data_in;
    logic        ctrl_wf_reset;
    logic        ctrl_init_act_valid;
    logic [15:0] ctrl_init_act_data;
    logic        ctrl_weights_ready;
    logic        ctrl_start_mlp;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_commit;
    logic        res_ready;
    logic [3:0]  mlp_state_in;
    logic [4:0]  mlp_cycle_cnt_in;
    logic [2:0]  mlp_current_layer_in;
    logic        mlp_layer_complete_in;
    logic [63:0] mlp_acc_in;
    logic        mlp_acc_valid_in;

    logic [1:0]         mlp_wf_push;
    logic [7:0]         mlp_wf_data_in;
    logic               mlp_wf_reset;
    logic               mlp_init_act_valid;
    logic [15:0]        mlp_init_act_data;
    logic               mlp_weights_ready;
    logic               mlp_start_mlp;
    logic signed [15:0] mlp_norm_gain;
    logic signed [31:0] mlp_norm_bias;
    logic [4:0]         mlp_norm_shift;
    logic signed [15:0] mlp_q_inv_scale;
    logic signed [7:0]  mlp_q_zero_point;
    logic [3:0]         mlp_state;
    logic [4:0]         mlp_cycle_cnt;
    logic [2:0]         mlp_current_layer;
    logic               mlp_layer_complete;
    logic               res_valid;
    logic [63:0]        res_data;
    logic [2:0]         res_layer;
    logic               res_overflow;
    logic               cfg_pending;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    tpu_cfg_bridge #(
        .NUM_COLS   (2),
        .ACC_W      (32),
        .FIFO_DEPTH (4)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .ctrl_wf_push          (ctrl_wf_push),
        .ctrl_wf_data_in       (ctrl_wf_data_in),
        .ctrl_wf_reset         (ctrl_wf_reset),
        .ctrl_init_act_valid   (ctrl_init_act_valid),
        .ctrl_init_act_data    (ctrl_init_act_data),
        .ctrl_weights_ready    (ctrl_weights_ready),
        .ctrl_start_mlp        (ctrl_start_mlp),
        .cfg_we                (cfg_we),
        .cfg_addr              (cfg_addr),
        .cfg_wdata             (cfg_wdata),
        .cfg_commit            (cfg_commit),
        .res_ready             (res_ready),
        .mlp_state_in          (mlp_state_in),
        .mlp_cycle_cnt_in      (mlp_cycle_cnt_in),
        .mlp_current_layer_in  (mlp_current_layer_in),
        .mlp_layer_complete_in (mlp_layer_complete_in),
        .mlp_acc_in            (mlp_acc_in),
        .mlp_acc_valid_in      (mlp_acc_valid_in),
        .mlp_wf_push           (mlp_wf_push),
        .mlp_wf_data_in        (mlp_wf_data_in),
        .mlp_wf_reset          (mlp_wf_reset),
        .mlp_init_act_valid    (mlp_init_act_valid),
        .mlp_init_act_data     (mlp_init_act_data),
        .mlp_weights_ready     (mlp_weights_ready),
        .mlp_start_mlp         (mlp_start_mlp),
        .mlp_norm_gain         (mlp_norm_gain),
        .mlp_norm_bias         (mlp_norm_bias),
        .mlp_norm_shift        (mlp_norm_shift),
        .mlp_q_inv_scale       (mlp_q_inv_scale),
        .mlp_q_zero_point      (mlp_q_zero_point),
        .mlp_state             (mlp_state),
        .mlp_cycle_cnt         (mlp_cycle_cnt),
        .mlp_current_layer     (mlp_current_layer),
        .mlp_layer_complete    (mlp_layer_complete),
        .res_valid             (res_valid),
        .res_data              (res_data),
        .res_layer             (res_layer),
        .res_overflow          (res_overflow),
        .cfg_pending           (cfg_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wf_push;
        logic [7:0]  wf_data;
        logic        wf_reset;
        logic        act_valid;
        logic [15:0] act_data;
        logic        wready;
        logic [3:0]  st;
        logic [4:0]  cyc;
        logic [2:0]  layer;
        logic        lc;
        logic        start;
        logic [42:0] expected;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_acc(input logic [31:0] acc0, input logic [2:0] layer);
        mlp_acc_valid_in     = 1'b1;
        mlp_acc_in           = {acc0 + 32'd100, acc0};
        mlp_current_layer_in = layer;
        tick();
        mlp_acc_valid_in     = 1'b0;
    endtask

    task automatic write_cfg(input logic [2:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic check_defaults(input string tag);
        check({tag, "_gain"},  64'(mlp_norm_gain),    64'(16'sd256));
        check({tag, "_bias"},  64'(mlp_norm_bias),    64'(32'sd0));
        check({tag, "_shift"}, 64'(mlp_norm_shift),   64'(5'd8));
        check({tag, "_invs"},  64'(mlp_q_inv_scale),  64'(16'sd256));
        check({tag, "_zp"},    64'(mlp_q_zero_point), 64'(8'sd0));
        check({tag, "_rvalid"},  64'(res_valid),   64'(0));
        check({tag, "_pending"}, 64'(cfg_pending), 64'(0));
    endtask

    initial begin
        vecs[0] = '{2'b01, 8'hA5, 1'b0, 1'b1, 16'h1234, 1'b0, 4'd3, 5'd17, 3'd2, 1'b1, 1'b1,
                    {2'b01, 8'hA5, 1'b0, 1'b1, 16'h1234, 1'b0, 4'd3, 5'd17, 3'd2, 1'b1, 1'b1}};
        vecs[1] = '{2'b10, 8'h3C, 1'b1, 1'b0, 16'hBEEF, 1'b1, 4'd0, 5'd0,  3'd7, 1'b0, 1'b0,
                    {2'b10, 8'h3C, 1'b1, 1'b0, 16'hBEEF, 1'b1, 4'd0, 5'd0,  3'd7, 1'b0, 1'b0}};
        vecs[2] = '{2'b11, 8'hFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 4'd15, 5'd31, 3'd5, 1'b1, 1'b1,
                    {2'b11, 8'hFF, 1'b1, 1'b1, 16'hFFFF, 1'b1, 4'd15, 5'd31, 3'd5, 1'b1, 1'b1}};
        vecs[3] = '{2'b00, 8'h00, 1'b0, 1'b0, 16'h0001, 1'b0, 4'd9, 5'd4,  3'd1, 1'b0, 1'b0,
                    {2'b00, 8'h00, 1'b0, 1'b0, 16'h0001, 1'b0, 4'd9, 5'd4,  3'd1, 1'b0, 1'b0}};

        reset = 1'b0;
        ctrl_wf_push = '0; ctrl_wf_data_in = '0; ctrl_wf_reset = 1'b0;
        ctrl_init_act_valid = 1'b0; ctrl_init_act_data = '0; ctrl_weights_ready = 1'b0;
        ctrl_start_mlp = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        res_ready = 1'b0; mlp_state_in = 4'd0; mlp_cycle_cnt_in = '0; mlp_current_layer_in = '0;
        mlp_layer_complete_in = 1'b0; mlp_acc_in = '0; mlp_acc_valid_in = 1'b0;

        // Reset release
        tick(); tick();
        reset = 1'b1;
        tick();
        check_defaults("reset");
        check("reset_ovf",   64'(res_overflow),  64'(0));
        check("reset_start", 64'(mlp_start_mlp), 64'(0));
        check("reset_data",  res_data, 64'h0);

        // Zero-latency forwarding and status, idle start passthrough
        for (int i = 0; i < 4; i++) begin
            ctrl_wf_push          = vecs[i].wf_push;
            ctrl_wf_data_in       = vecs[i].wf_data;
            ctrl_wf_reset         = vecs[i].wf_reset;
            ctrl_init_act_valid   = vecs[i].act_valid;
            ctrl_init_act_data    = vecs[i].act_data;
            ctrl_weights_ready    = vecs[i].wready;
            mlp_state_in          = vecs[i].st;
            mlp_cycle_cnt_in      = vecs[i].cyc;
            mlp_current_layer_in  = vecs[i].layer;
            mlp_layer_complete_in = vecs[i].lc;
            ctrl_start_mlp        = vecs[i].start;
            #1;
            check($sformatf("fwd_vec%0d", i),
                  64'({mlp_wf_push, mlp_wf_data_in, mlp_wf_reset, mlp_init_act_valid,
                       mlp_init_act_data, mlp_weights_ready, mlp_state, mlp_cycle_cnt,
                       mlp_current_layer, mlp_layer_complete, mlp_start_mlp}),
                  64'(vecs[i].expected));
        end
        ctrl_start_mlp = 1'b0;
        mlp_current_layer_in = '0;
        tick();

        // Commit deferred while the MLP is busy
        mlp_state_in = 4'd3;
        write_cfg(3'd0, 32'd512);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        check("busy_gain",    64'(mlp_norm_gain), 64'(16'sd256));
        check("busy_pending", 64'(cfg_pending),   64'(1));
        tick();
        check("busy_gain2",   64'(mlp_norm_gain), 64'(16'sd256));
        mlp_state_in = 4'd0;
        #1;
        check("idle_no_start", 64'(mlp_start_mlp), 64'(0));
        tick();
        check("commit_gain",    64'(mlp_norm_gain), 64'(16'sd512));
        check("commit_pending", 64'(cfg_pending),   64'(0));

        // Truncation of a shift write to 5 bits, commit from idle
        write_cfg(3'd2, 32'h0000_002A);
        write_cfg(3'd5, 32'hFFFF_FFFF);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        tick();
        check("shift_trunc", 64'(mlp_norm_shift), 64'(5'd10));
        check("gain_kept",   64'(mlp_norm_gain),  64'(16'sd512));

        // Write on the commit edge is included in the copy
        mlp_state_in = 4'd3;
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        mlp_state_in = 4'd0;
        write_cfg(3'd1, 32'hFFFF_FFFB);
        check("same_edge_bias", 64'(mlp_norm_bias), 64'(-32'sd5));

        // Start deferred behind a pending commit, multiple starts collapse
        mlp_state_in = 4'd3;
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        ctrl_start_mlp = 1'b1;
        #1;
        check("gated_start", 64'(mlp_start_mlp), 64'(0));
        tick();
        ctrl_start_mlp = 1'b0; tick();
        ctrl_start_mlp = 1'b1; tick();
        ctrl_start_mlp = 1'b0;
        check("gated_start2", 64'(mlp_start_mlp), 64'(0));
        mlp_state_in = 4'd0;
        #1;
        check("copy_cycle_start", 64'(mlp_start_mlp), 64'(0));
        tick();
        check("deferred_start", 64'(mlp_start_mlp), 64'(1));
        check("start_pending",  64'(cfg_pending),   64'(1));
        tick();
        check("start_one_cycle", 64'(mlp_start_mlp), 64'(0));
        check("start_done",      64'(cfg_pending),   64'(0));
        tick();
        check("no_second_start", 64'(mlp_start_mlp), 64'(0));

        // FIFO fill, overflow, drain, overflow clear
        res_ready = 1'b0;
        push_acc(32'd1, 3'd2);
        check("fifo_valid", 64'(res_valid), 64'(1));
        check("fifo_head",  64'(res_data[31:0]), 64'(1));
        check("fifo_layer", 64'(res_layer), 64'(2));
        for (int k = 2; k <= 4; k++) push_acc(32'(k), 3'd2);
        check("fifo_no_ovf", 64'(res_overflow), 64'(0));
        push_acc(32'd5, 3'd2);
        check("fifo_ovf", 64'(res_overflow), 64'(1));
        res_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("drain_%0d", k), res_data, {32'(k) + 32'd100, 32'(k)});
            tick();
        end
        res_ready = 1'b0;
        check("drained_empty", 64'(res_valid), 64'(0));
        write_cfg(3'd7, 32'd0);
        check("ovf_clear", 64'(res_overflow), 64'(0));

        // Full FIFO with simultaneous push and pop
        for (int k = 1; k <= 4; k++) push_acc(32'(k), 3'd1);
        res_ready = 1'b1;
        push_acc(32'd9, 3'd6);
        check("pp_no_ovf", 64'(res_overflow), 64'(0));
        begin
            logic [31:0] exp_seq [4];
            exp_seq = '{32'd2, 32'd3, 32'd4, 32'd9};
            for (int k = 0; k < 4; k++) begin
                check($sformatf("pp_drain_%0d", k), 64'(res_data[31:0]), 64'(exp_seq[k]));
                check($sformatf("pp_layer_%0d", k), 64'(res_layer), (k == 3) ? 64'(6) : 64'(1));
                tick();
            end
        end
        check("pp_empty", 64'(res_valid), 64'(0));
        res_ready = 1'b0;

        // Reset mid-drain with a pending commit and latched start
        push_acc(32'd7, 3'd3);
        push_acc(32'd8, 3'd3);
        mlp_state_in = 4'd3;
        write_cfg(3'd0, 32'd1000);
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        ctrl_start_mlp = 1'b1; tick(); ctrl_start_mlp = 1'b0;
        res_ready = 1'b1; tick();
        reset = 1'b0;
        #1;
        check_defaults("midrst");
        check("midrst_start", 64'(mlp_start_mlp), 64'(0));
        res_ready = 1'b0;
        mlp_state_in = 4'd0;
        tick(); tick();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("post_rst_start_%0d", k), 64'(mlp_start_mlp), 64'(0));
        end
        cfg_commit = 1'b1; tick(); cfg_commit = 1'b0;
        tick();
        check("post_rst_shadow", 64'(mlp_norm_gain), 64'(16'sd256));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
